alu_share_arbiter: RTL and testbench

//  Shares one ALU between two requesters (0: execute stage, 1: sort-compare/address helper).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_decode.sv | 34 +++
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   ALUOp encodings, ALU Operation encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct -> ALU Operation decoder.
//   aluop     in  2  ALUOp from the granted requester
//   funct     in  4  {funct7[5], funct3}
//   operation out 4  ALU Operation code (ADD on illegal combinations)
//   err       out 1  illegal ALUOp/Funct combination
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output logic [3:0] operation,
  output logic       err
);

  always_comb begin
    operation = OP_ADD;
    err       = 1'b0;
    case (aluop)
      ALUOP_MEM: if (funct == 4'b0001) operation = OP_SLL;
      ALUOP_BR:  operation = OP_SUB;
      ALUOP_R: begin
        case (funct)
          4'b0000: operation = OP_ADD;
          4'b1000: operation = OP_SUB;
          4'b0111: operation = OP_AND;
          4'b0110: operation = OP_OR;
          default: err = 1'b1;
        endcase
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU.
//   clk, reset         clock, async active-low reset
//   req_*              per-requester request channel (valid/ready, packed {r1,r0})
//   rsp_*              registered response, rsp_valid one-hot to the owner
//   alu_a/b/operation  registered drive to the shared ALU
//   alu_result/zero    combinational return from the shared ALU
// One operation in flight: IDLE (accept) -> EXEC (ALU runs) -> RESP (hold until taken).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_aluop,
  input  logic [7:0]           req_funct,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OP_W-1:0]      alu_operation,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero
);

  state_t     state;
  logic       rr_ptr;
  logic       owner;
  logic       err_q;
  logic       g;
  logic [1:0] aluop_g;
  logic [3:0] funct_g;
  logic [WIDTH-1:0] a_g, b_g;
  logic [OP_W-1:0]  dec_op;
  logic       dec_err;
  logic       accept;

  // Contention resolved by rr_ptr; a lone requester always wins.
  always_comb begin
    g       = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    aluop_g = g ? req_aluop[3:2] : req_aluop[1:0];
    funct_g = g ? req_funct[7:4] : req_funct[3:0];
    a_g     = g ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    b_g     = g ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  end

  // Gated by reset so no ready leaks out while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (reset && state == S_IDLE && |req_valid) req_ready[g] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  alu_op_decode u_dec (
    .aluop     (aluop_g),
    .funct     (funct_g),
    .operation (dec_op),
    .err       (dec_err)
  );

  // alu_* are the operand latches themselves: loaded on accept, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      err_q         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      rsp_valid     <= 2'b00;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a         <= a_g;
            alu_b         <= b_g;
            alu_operation <= dec_op;
            err_q         <= dec_err;
            owner         <= g;
            rr_ptr        <= ~g;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Illegal ops still run the ALU but report a zeroed result.
          rsp_result <= err_q ? '0 : alu_result;
          rsp_zero   <= err_q ? 1'b0 : alu_zero;
          rsp_err    <= err_q;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_aluop;
  logic [7:0]       req_funct;
  logic [2*WIDTH-1:0] req_a, req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_operation;
  logic             alu_zero;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  // Behavioural shared ALU
  always_comb begin
    case (alu_operation)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SLL:  alu_result = alu_a << alu_b[5:0];
      OP_SUB:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] f,
                         input logic [63:0] a, input logic [63:0] b);
    if (r == 0) begin
      req_aluop[1:0] = op; req_funct[3:0] = f;
      req_a[63:0] = a;     req_b[63:0] = b;
    end else begin
      req_aluop[3:2] = op; req_funct[7:4] = f;
      req_a[127:64] = a;   req_b[127:64] = b;
    end
  endtask

  // Called in IDLE with requests set up and rsp_ready high; ends back in IDLE.
  task automatic run_op(input string tag, input int own, input logic [3:0] op,
                        input logic [63:0] res, input logic z, input logic e);
    logic [1:0] oh;
    oh = (own == 1) ? 2'b10 : 2'b01;
    chk({tag, ".grant"}, 64'(req_ready), 64'(oh));
    step();
    chk({tag, ".op"}, 64'(alu_operation), 64'(op));
    chk({tag, ".exec_nordy"}, 64'(req_ready), 64'(2'b00));
    step();
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, ".result"}, rsp_result, res);
    chk({tag, ".zero"}, 64'(rsp_zero), 64'(z));
    chk({tag, ".err"}, 64'(rsp_err), 64'(e));
    step();
    chk({tag, ".done"}, 64'(rsp_valid), 64'(2'b00));
  endtask

  initial begin
    // Test 1: reset with both requesting
    reset = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    set_req(0, ALUOP_R, 4'b0000, 64'd5, 64'd7);
    set_req(1, ALUOP_MEM, 4'b0001, 64'd1, 64'd3);
    repeat (3) step();
    chk("rst.req_ready", 64'(req_ready), 0);
    chk("rst.rsp_valid", 64'(rsp_valid), 0);
    chk("rst.rsp_result", rsp_result, 0);
    chk("rst.rsp_zero", 64'(rsp_zero), 0);
    chk("rst.rsp_err", 64'(rsp_err), 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_b", alu_b, 0);
    chk("rst.alu_op", 64'(alu_operation), 0);
    reset = 1'b1;
    #1;
    chk("t1.first_grant_r0", 64'(req_ready), 64'(2'b01));

    // Test 2 + 5: r0 add 5+7, response held off for 10 cycles
    step();
    chk("t2.exec_op", 64'(alu_operation), 64'(OP_ADD));
    chk("t2.exec_a", alu_a, 64'd5);
    chk("t2.exec_b", alu_b, 64'd7);
    chk("t2.exec_novalid", 64'(rsp_valid), 0);
    step();
    chk("t2.valid", 64'(rsp_valid), 64'(2'b01));
    chk("t2.result", rsp_result, 64'd12);
    chk("t2.zero", 64'(rsp_zero), 0);
    chk("t2.err", 64'(rsp_err), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5.hold_valid", 64'(rsp_valid), 64'(2'b01));
      chk("t5.hold_result", rsp_result, 64'd12);
      chk("t5.no_ready", 64'(req_ready), 0);
    end
    rsp_ready = 2'b10;  // non-owner ready must be ignored
    step();
    chk("t5.nonowner_ignored", 64'(rsp_valid), 64'(2'b01));
    rsp_ready = 2'b11;
    step();
    chk("t5.released", 64'(rsp_valid), 0);

    // Test 3: both requesting, grants alternate (r1 next since r0 went last)
    set_req(0, ALUOP_BR, 4'b0000, 64'd9, 64'd9);
    set_req(1, ALUOP_MEM, 4'b0001, 64'd1, 64'd3);
    #1;
    run_op("t3.r1a", 1, OP_SLL, 64'd8, 1'b0, 1'b0);
    run_op("t3.r0", 0, OP_SUB, 64'd0, 1'b1, 1'b0);
    run_op("t3.r1b", 1, OP_SLL, 64'd8, 1'b0, 1'b0);

    // Test 4: errors and remaining decodes, r1 alone (never starved)
    req_valid = 2'b10;
    set_req(1, ALUOP_R, 4'b0011, 64'd1, 64'd3);
    #1;
    run_op("t4.badfunct", 1, OP_ADD, 64'd0, 1'b0, 1'b1);
    set_req(1, 2'b11, 4'b0000, 64'd1, 64'd3);
    #1;
    run_op("t4.aluop11", 1, OP_ADD, 64'd0, 1'b0, 1'b1);
    set_req(1, ALUOP_R, 4'b0111, 64'd12, 64'd10);
    #1;
    run_op("t4.and", 1, OP_AND, 64'd8, 1'b0, 1'b0);
    set_req(1, ALUOP_R, 4'b0110, 64'd12, 64'd10);
    #1;
    run_op("t4.or", 1, OP_OR, 64'd14, 1'b0, 1'b0);
    set_req(1, ALUOP_R, 4'b1000, 64'd3, 64'd5);
    #1;
    run_op("t4.subwrap", 1, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    set_req(1, ALUOP_MEM, 4'b0000, 64'd5, 64'd7);
    #1;
    run_op("t4.memadd", 1, OP_ADD, 64'd12, 1'b0, 1'b0);

    // Test 6: reset during EXEC discards the op
    req_valid = 2'b01;
    set_req(0, ALUOP_R, 4'b0000, 64'd5, 64'd7);
    #1;
    chk("t6.grant", 64'(req_ready), 64'(2'b01));
    step();
    chk("t6.in_exec", 64'(alu_a), 64'd5);
    reset = 1'b0;
    #1;
    chk("t6.async_clear_a", alu_a, 0);
    chk("t6.async_clear_op", 64'(alu_operation), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6.no_rsp", 64'(rsp_valid), 0);
    end
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    run_op("t6.after", 0, OP_ADD, 64'd12, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
